// File: rtl/mem_engine_pkg.sv
// Shared definitions for the memory copy/fill engine: FSM encoding,
// operation modes and default bus widths.
package mem_engine_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_LEN_W  = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/addr_step_counter.sv
// Loadable address pointer that steps by one word and wraps modulo 2^ADDR_W.
module addr_step_counter
    import mem_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_value,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_value
);

    logic [ADDR_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_value;
        end else if (i_inc) begin
            r_value <= r_value + ADDR_W'(1);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/mem_copy_engine.sv
// Block COPY / FILL engine driving the Data_Memory port set. Every output is
// registered from the current FSM state, so bus activity trails the state by one cycle.
module mem_copy_engine
    import mem_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_mode;
    logic [DATA_W-1:0] r_fill_value;
    logic [LEN_W-1:0]  r_remaining;

    logic              r_busy;
    logic              r_done;
    logic [LEN_W-1:0]  r_words_done;
    logic [ADDR_W-1:0] r_mem_access_addr;
    logic [DATA_W-1:0] r_mem_write_data;
    logic              r_mem_write_en;
    logic              r_mem_read;

    logic              w_busy;
    logic              w_done;
    logic [LEN_W-1:0]  w_words_done;
    logic [ADDR_W-1:0] w_mem_access_addr;
    logic [DATA_W-1:0] w_mem_write_data;
    logic              w_mem_write_en;
    logic              w_mem_read;

    logic              w_accept;
    logic              w_in_wr;
    logic [ADDR_W-1:0] w_src_ptr;
    logic [ADDR_W-1:0] w_dst_ptr;

    // The done cycle still belongs to FIN from the outside, so start is refused there too.
    assign w_accept = (r_state == ST_IDLE) && start && !r_done;
    assign w_in_wr  = (r_state == ST_WR);

    addr_step_counter #(.ADDR_W(ADDR_W)) u_src_ptr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_load_value (src_addr),
        .i_inc        (w_in_wr),
        .o_value      (w_src_ptr)
    );

    addr_step_counter #(.ADDR_W(ADDR_W)) u_dst_ptr (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_load_value (dst_addr),
        .i_inc        (w_in_wr),
        .o_value      (w_dst_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (length == '0) begin
                        w_next_state = ST_FIN;
                    end else if (mode == MODE_COPY) begin
                        w_next_state = ST_RD;
                    end else begin
                        w_next_state = ST_WR;
                    end
                end
            end
            ST_RD:    w_next_state = ST_RWAIT;
            ST_RWAIT: w_next_state = ST_WR;
            ST_WR: begin
                if (r_remaining == LEN_W'(1)) begin
                    w_next_state = ST_FIN;
                end else if (r_mode == MODE_COPY) begin
                    w_next_state = ST_RD;
                end else begin
                    w_next_state = ST_WR;
                end
            end
            ST_FIN:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state inside {ST_RD, ST_RWAIT, ST_WR}) ||
                 (w_next_state inside {ST_RD, ST_RWAIT, ST_WR});
        w_done            = (r_state == ST_FIN);
        w_mem_read        = (r_state == ST_RD);
        w_mem_write_en    = w_in_wr;
        w_mem_access_addr = r_mem_access_addr;
        w_mem_write_data  = r_mem_write_data;
        w_words_done      = r_words_done;
        if (r_state == ST_RD) begin
            w_mem_access_addr = w_src_ptr;
        end else if (w_in_wr) begin
            w_mem_access_addr = w_dst_ptr;
            // Read data returned for the preceding RD is valid exactly at this edge.
            w_mem_write_data  = (r_mode == MODE_COPY) ? mem_read_data : r_fill_value;
        end
        if (w_accept) begin
            w_words_done = '0;
        end else if (r_mem_write_en) begin
            w_words_done = r_words_done + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_words_done      <= '0;
            r_mem_access_addr <= '0;
            r_mem_write_data  <= '0;
            r_mem_write_en    <= 1'b0;
            r_mem_read        <= 1'b0;
        end else begin
            r_busy            <= w_busy;
            r_done            <= w_done;
            r_words_done      <= w_words_done;
            r_mem_access_addr <= w_mem_access_addr;
            r_mem_write_data  <= w_mem_write_data;
            r_mem_write_en    <= w_mem_write_en;
            r_mem_read        <= w_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= MODE_COPY;
            r_fill_value <= '0;
            r_remaining  <= '0;
        end else if (w_accept) begin
            r_mode       <= mode;
            r_fill_value <= fill_value;
            r_remaining  <= length;
        end else if (w_in_wr) begin
            r_remaining  <= r_remaining - LEN_W'(1);
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign words_done      = r_words_done;
    assign mem_access_addr = r_mem_access_addr;
    assign mem_write_data  = r_mem_write_data;
    assign mem_write_en    = r_mem_write_en;
    assign mem_read        = r_mem_read;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomised bench for mem_copy_engine against a word-array reference model
// with a synchronous-read Data_Memory model.
module tb_mem_copy_engine;
    import mem_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] length = '0;
    logic [15:0] fill_value = '0;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data = '0;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] wr_addrs[$];
    int          wr_count = 0;
    int          rd_count = 0;
    int          both_high = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .length          (length),
        .fill_value      (fill_value),
        .busy            (busy),
        .done            (done),
        .words_done      (words_done),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_access_addr] <= mem_write_data;
            wr_addrs.push_back(mem_access_addr);
            wr_count++;
        end
        if (mem_read) begin
            mem_read_data <= mem[mem_access_addr];
            rd_count++;
        end
        if (mem_read && mem_write_en) both_high++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input logic [15:0] f, input bit inject);
        int k;
        int lat;
        bit seen;
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f; start = 1'b1;
        wr_count = 0; rd_count = 0; wr_addrs.delete();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
        length = 16'($urandom); fill_value = 16'($urandom);
        check_eq("busy_rise", {31'd0, busy}, {31'd0, (n != 0)});
        lat = (n == 0) ? 1 : (m == MODE_COPY) ? 3 * int'(n) + 1 : int'(n) + 1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < lat + 8) begin
            @(negedge clk);
            k++;
            if (inject && k == 2) start = 1'b1;
            if (inject && k == 3) start = 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_eq("done_seen", {31'd0, seen}, 32'd1);
        check_eq("latency", k, lat);
        check_eq("words_done", {16'd0, words_done}, {16'd0, n});
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        check_eq("wr_count", wr_count, int'(n));
        check_eq("rd_count", rd_count, (m == MODE_COPY) ? int'(n) : 0);
        for (int i = 0; i < int'(n); i++) begin
            a = d + 16'(i);
            b = s + 16'(i);
            ref_mem[a] = (m == MODE_COPY) ? ref_mem[b] : f;
        end
        for (int i = 0; i <= int'(n); i++) begin
            a = d + 16'(i);
            check_eq("mem_word", {16'd0, mem[a]}, {16'd0, ref_mem[a]});
            if (i < int'(n) && i < wr_addrs.size())
                check_eq("wr_order", {16'd0, wr_addrs[i]}, {16'd0, a});
        end
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int nw;
        bit done_seen;
        logic [15:0] d;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_we_rd", {30'd0, mem_write_en, mem_read}, 32'd0);
        check_eq("rst_words", {16'd0, words_done}, 32'd0);
        check_eq("rst_buses", {mem_access_addr, mem_write_data}, 32'd0);
        rst = 1'b0;

        run_op(MODE_FILL, 16'h0000, 16'h0010, 16'd4, 16'hBEEF, 1'b0);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333;
        run_op(MODE_COPY, 16'h0000, 16'h0020, 16'd3, 16'h0000, 1'b0);
        run_op(MODE_COPY, 16'h0100, 16'h0200, 16'd0, 16'h5555, 1'b0);
        run_op(MODE_FILL, 16'h0000, 16'hFFFE, 16'd3, 16'h00AA, 1'b0);
        run_op(MODE_COPY, 16'h0300, 16'h0400, 16'd2, 16'h0000, 1'b1);
        run_op(MODE_COPY, 16'h0500, 16'h0502, 16'd6, 16'h0000, 1'b0);
        run_op(MODE_COPY, 16'hFFFD, 16'h0600, 16'd5, 16'h0000, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [15:0] s;
            s = 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(0, 4)) : 16'($urandom);
            run_op(1'($urandom), s, d, 16'($urandom_range(0, 12)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an 8-word FILL, asserted while the third write is presented.
        d = 16'h0700;
        @(negedge clk);
        mode = MODE_FILL; dst_addr = d; length = 16'd8; fill_value = 16'hC0DE; start = 1'b1;
        wr_count = 0;
        @(negedge clk);
        start = 1'b0;
        nw = 0;
        for (int k = 0; k < 20 && nw < 3; k++) begin
            if (mem_write_en) nw++;
            if (nw < 3) @(negedge clk);
        end
        check_eq("rst_mid_reach", nw, 3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_we", {31'd0, mem_write_en}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done) done_seen = 1'b1;
            @(negedge clk);
        end
        check_eq("rst_mid_nodone", {31'd0, done_seen}, 32'd0);
        check_eq("rst_mid_wr_count", wr_count, 3);
        for (int i = 0; i < 4; i++) begin
            a = d + 16'(i);
            if (i < 3) ref_mem[a] = 16'hC0DE;
            check_eq("rst_mid_mem", {16'd0, mem[a]}, {16'd0, ref_mem[a]});
        end

        check_eq("rd_we_exclusive", both_high, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side block that drives the Data_Memory port set (mem_access_addr, mem_write_data, mem_write_en, mem_read, mem_read_data).
- Performs block COPY (src to dst) and block FILL (constant to dst) on request from the CPU control path.
- Frees the core from per-word load/store loops for memset/memcpy-type operations and memory init during test.
- Sits between the control unit and Data_Memory, muxed with the CPU's load/store path by the top level while busy=1.

Parameters:
- ADDR_W, 16, address width; matches mem_access_addr.
- DATA_W, 16, data word width; matches mem_write_data and mem_read_data.
- LEN_W, 16, width of the word-count request.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0=COPY, 1=FILL; sampled with start.
- src_addr  in  ADDR_W  COPY source base; sampled with start.
- dst_addr  in  ADDR_W  destination base; sampled with start.
- length  in  LEN_W  number of words; sampled with start.
- fill_value  in  DATA_W  FILL data; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- words_done  out  LEN_W  count of words written in the current or last operation.
- mem_access_addr  out  ADDR_W  to Data_Memory.
- mem_write_data  out  DATA_W  to Data_Memory.
- mem_write_en  out  1  to Data_Memory.
- mem_read  out  1  to Data_Memory.
- mem_read_data  in  DATA_W  from Data_Memory.

Behaviour:
- Data_Memory contract (fixed):
  - Write commits on the rising edge where mem_write_en=1.
  - Read data is valid one cycle after the edge at which addr/mem_read are presented.
- All outputs are registered.
- Reset values: busy, done, mem_write_en and mem_read are 0; all buses and words_done are 0; FSM goes to IDLE.
- FSM states: IDLE, RD, RWAIT, WR, FIN.
- IDLE:
  - On start=1, latch mode, src, dst, length and fill_value, and clear words_done.
  - length=0 goes to FIN with no memory access.
  - Otherwise COPY goes to RD and FILL goes to WR.
  - busy goes high the cycle after start is sampled.
- RD: drive addr=src_ptr, mem_read=1, mem_write_en=0; next state is RWAIT.
- RWAIT: drive mem_read=0; next state is WR.
- WR:
  - Drive addr=dst_ptr, mem_write_en=1, mem_read=0.
  - mem_write_data is mem_read_data captured at the end of RWAIT (COPY) or fill_value (FILL).
  - On leaving WR: words_done+1, src_ptr+1, dst_ptr+1.
  - If remaining=0, go to FIN; otherwise go to RD (COPY) or stay in WR (FILL).
- FIN: done=1 for exactly one cycle, busy=0, all mem enables 0; next state is IDLE.
- Throughput: COPY is 3 cycles/word, FILL is 1 cycle/word.
- Latency, measured with start sampled at edge E:
  - COPY: done is high in the cycle after edge E+3N+1.
  - FILL: done is high in the cycle after edge E+N+1.
  - length=0: done is high in the cycle after edge E+1.
- Pointers wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000); no error is raised.
- Overlapping regions: strictly ascending word order. Overlap with dst>src replicates source words (defined, not corrected).
- start while busy or in FIN is ignored; no queueing.
- Input changes after the start cycle have no effect.
- rst asserted mid-operation:
  - At the next edge, mem_write_en=0 and busy=0, and the FSM returns to IDLE.
  - done is not pulsed.
  - Words already committed stay written.
- mem_read and mem_write_en are never high in the same cycle.

Decomposition:
- Shared package mem_engine_pkg holds:
  - the state encoding (IDLE=0, RD=1, RWAIT=2, WR=3, FIN=4);
  - the MODE_COPY/MODE_FILL constants;
  - the default widths.
- One sub-module: addr_step_counter, a loadable ADDR_W incrementer with wrap, instantiated twice (src_ptr, dst_ptr).
- The remaining-word down-counter lives in the top module.

Test Plan:
- FILL: dst=0x0010, len=4, fill=0xBEEF.
  - Writes 0x0010..0x0013 on 4 consecutive cycles.
  - done 5 cycles after the start edge; words_done=4.
- COPY: preload 0x0000..0x0002 with 0x1111/0x2222/0x3333, then COPY src=0x0000, dst=0x0020, len=3.
  - Reading back gives 0x1111/0x2222/0x3333 at 0x0020..0x0022.
  - done at start edge+10.
- length=0: start -> done one cycle later; mem_write_en and mem_read stay 0 throughout.
- Wrap: FILL dst=0xFFFE, len=3, fill=0x00AA -> writes to 0xFFFE, 0xFFFF, 0x0000.
- Busy interlock: second start, with different args, during COPY len=2 -> ignored; only the first transfer occurs.
- Reset mid-FILL: FILL len=8, rst high after 3 writes.
  - Next cycle mem_write_en=0 and busy=0; no done pulse.
  - Exactly 3 words are written.
